// File: rtl/resource_sched_pkg.sv
// Shared types and constants for the resource scheduler: owner encodings,
// in-flight tag layout, arbitration modes and the per-owner squash helper.
package resource_sched_pkg;

    localparam logic OWNER_P1 = 1'b0;
    localparam logic OWNER_P2 = 1'b1;

    typedef enum logic {
        MODE_RR  = 1'b0,
        MODE_TDM = 1'b1
    } mode_e;

    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

    // Drop the valid bit of a tag whose owner is being flushed this cycle.
    function automatic tag_t squash_tag(input tag_t t, input logic f1, input logic f2);
        tag_t r;
        r = t;
        if ((f1 && (t.owner == OWNER_P1)) || (f2 && (t.owner == OWNER_P2))) begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sched_tag_pipe.sv
// RES_LATENCY-deep shift register of {valid, owner} tags that mirrors the
// resource pipeline, with per-owner squash on flush.
module sched_tag_pipe
    import resource_sched_pkg::*;
#(
    parameter int unsigned RES_LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    input  tag_t i_tag,
    input  logic i_flush_1,
    input  logic i_flush_2,
    output tag_t o_last,
    output logic o_busy
);

    tag_t r_stage [RES_LATENCY];
    logic w_busy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned k = 0; k < RES_LATENCY; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= squash_tag(i_tag, i_flush_1, i_flush_2);
            for (int unsigned k = 1; k < RES_LATENCY; k++) begin
                r_stage[k] <= squash_tag(r_stage[k-1], i_flush_1, i_flush_2);
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int unsigned k = 0; k < RES_LATENCY; k++) begin
            w_busy = w_busy | r_stage[k].valid;
        end
    end

    assign o_last = r_stage[RES_LATENCY-1];
    assign o_busy = w_busy;

endmodule

// File: rtl/resource_scheduler.sv
// Arbitrates the shared resource between two pipelines (round-robin or fixed
// TDM slots), routes results back by owner tag and counts stall cycles.
module resource_scheduler
    import resource_sched_pkg::*;
#(
    parameter int unsigned RES_LATENCY = 2,
    parameter int unsigned SLOT_LEN    = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode_tdm,
    input  logic             req_1,
    input  logic             req_2,
    input  logic             flush_1,
    input  logic             flush_2,
    output logic             grant_1,
    output logic             grant_2,
    output logic             rsp_valid_1,
    output logic             rsp_valid_2,
    output logic [CNT_W-1:0] stall_cnt_1,
    output logic [CNT_W-1:0] stall_cnt_2,
    output logic             busy
);

    localparam int unsigned SLOT_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_LEN - 1);

    logic              r_rr_ptr;
    logic [SLOT_W-1:0] r_slot_cnt;
    logic              r_slot_owner;
    mode_e             r_mode;
    logic [CNT_W-1:0]  r_stall_1;
    logic [CNT_W-1:0]  r_stall_2;

    mode_e w_mode;
    logic  w_mode_chg;
    logic  w_ereq_1;
    logic  w_ereq_2;
    logic  w_grant_1;
    logic  w_grant_2;
    tag_t  w_tag_in;
    tag_t  w_last;
    logic  w_pipe_busy;

    assign w_mode     = mode_e'(mode_tdm);
    assign w_mode_chg = (w_mode != r_mode);
    assign w_ereq_1   = req_1 & ~flush_1;
    assign w_ereq_2   = req_2 & ~flush_2;

    always_comb begin
        w_grant_1 = 1'b0;
        w_grant_2 = 1'b0;
        if (reset) begin
            if (w_mode == MODE_TDM) begin
                w_grant_1 = w_ereq_1 & (r_slot_owner == OWNER_P1);
                w_grant_2 = w_ereq_2 & (r_slot_owner == OWNER_P2);
            end else if (w_ereq_1 && w_ereq_2) begin
                w_grant_1 = (r_rr_ptr == OWNER_P1);
                w_grant_2 = (r_rr_ptr == OWNER_P2);
            end else begin
                w_grant_1 = w_ereq_1;
                w_grant_2 = w_ereq_2;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_mode <= w_mode;
        if (!reset) begin
            r_rr_ptr <= OWNER_P1;
        end else if ((w_mode == MODE_RR) && w_ereq_1 && w_ereq_2) begin
            r_rr_ptr <= ~r_rr_ptr;
        end
    end

    // The slot counter parks at slot 0 / owner P1 outside TDM, so entering TDM
    // always starts with a full P1 slot no matter how long RR ran.
    always_ff @(posedge clk) begin
        if (!reset || w_mode_chg || (w_mode == MODE_RR)) begin
            r_slot_cnt   <= '0;
            r_slot_owner <= OWNER_P1;
        end else if (r_slot_cnt == SLOT_LAST) begin
            r_slot_cnt   <= '0;
            r_slot_owner <= ~r_slot_owner;
        end else begin
            r_slot_cnt   <= r_slot_cnt + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_1 <= '0;
            r_stall_2 <= '0;
        end else begin
            if (req_1 && !w_grant_1 && (r_stall_1 != '1)) begin
                r_stall_1 <= r_stall_1 + CNT_W'(1);
            end
            if (req_2 && !w_grant_2 && (r_stall_2 != '1)) begin
                r_stall_2 <= r_stall_2 + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_tag_in       = '0;
        w_tag_in.valid = w_grant_1 | w_grant_2;
        w_tag_in.owner = w_grant_2 ? OWNER_P2 : OWNER_P1;
    end

    sched_tag_pipe #(
        .RES_LATENCY (RES_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .i_tag     (w_tag_in),
        .i_flush_1 (flush_1),
        .i_flush_2 (flush_2),
        .o_last    (w_last),
        .o_busy    (w_pipe_busy)
    );

    assign grant_1     = w_grant_1;
    assign grant_2     = w_grant_2;
    assign rsp_valid_1 = reset & w_last.valid & (w_last.owner == OWNER_P1) & ~flush_1;
    assign rsp_valid_2 = reset & w_last.valid & (w_last.owner == OWNER_P2) & ~flush_2;
    assign busy        = reset & w_pipe_busy;
    assign stall_cnt_1 = r_stall_1;
    assign stall_cnt_2 = r_stall_2;

endmodule

// File: tb/tb_resource_scheduler.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs, a negedge
// monitor pops and compares them against the scheduler.
module tb_resource_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mode_tdm = 1'b0;
    logic       req_1 = 1'b0;
    logic       req_2 = 1'b0;
    logic       flush_1 = 1'b0;
    logic       flush_2 = 1'b0;
    logic       grant_1;
    logic       grant_2;
    logic       rsp_valid_1;
    logic       rsp_valid_2;
    logic [3:0] stall_cnt_1;
    logic [3:0] stall_cnt_2;
    logic       busy;

    typedef struct {
        string      nm;
        logic [4:0] v;
        logic       cc;
        logic [3:0] c1;
        logic [3:0] c2;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    resource_scheduler #(
        .RES_LATENCY (2),
        .SLOT_LEN    (4),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode_tdm    (mode_tdm),
        .req_1       (req_1),
        .req_2       (req_2),
        .flush_1     (flush_1),
        .flush_2     (flush_2),
        .grant_1     (grant_1),
        .grant_2     (grant_2),
        .rsp_valid_1 (rsp_valid_1),
        .rsp_valid_2 (rsp_valid_2),
        .stall_cnt_1 (stall_cnt_1),
        .stall_cnt_2 (stall_cnt_2),
        .busy        (busy)
    );

    task automatic step(input string nm, input logic rst, input logic md,
                        input logic q1, input logic q2, input logic f1, input logic f2,
                        input logic eg1, input logic eg2, input logic er1, input logic er2,
                        input logic eb, input logic cc, input logic [3:0] ec1,
                        input logic [3:0] ec2);
        exp_t x;
        @(posedge clk);
        #1;
        reset    = rst;
        mode_tdm = md;
        req_1    = q1;
        req_2    = q2;
        flush_1  = f1;
        flush_2  = f2;
        x.nm = nm;
        x.v  = {eg1, eg2, er1, er2, eb};
        x.cc = cc;
        x.c1 = ec1;
        x.c2 = ec2;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if ({grant_1, grant_2, rsp_valid_1, rsp_valid_2, busy} !== e.v) begin
                n_err++;
                $display("FAIL %s {g1,g2,r1,r2,busy}: got %b want %b", e.nm,
                         {grant_1, grant_2, rsp_valid_1, rsp_valid_2, busy}, e.v);
            end
            if (e.cc) begin
                n_cmp++;
                if ({stall_cnt_1, stall_cnt_2} !== {e.c1, e.c2}) begin
                    n_err++;
                    $display("FAIL %s stall_cnt: got %0d/%0d want %0d/%0d", e.nm,
                             stall_cnt_1, stall_cnt_2, e.c1, e.c2);
                end
            end
        end
    end

    initial begin
        logic [11:0] pat;
        int          tally;
        logic        g2;
        pat = 12'b0111_0100_1101;

        // Reset held with both requesting
        for (int c = 0; c < 3; c++)
            step($sformatf("reset c%0d", c), 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0, 4'd0);

        // RR contention, first grant after release goes to pipeline 1
        for (int c = 0; c < 9; c++)
            step($sformatf("rr c%0d", c), 1, 0, c < 6, c < 6, 0, 0,
                 (c < 6) && (c % 2 == 0), (c < 6) && (c % 2 == 1),
                 (c >= 2) && (c <= 6) && (c % 2 == 0), (c >= 3) && (c <= 7) && (c % 2 == 1),
                 (c >= 1) && (c <= 7), 1,
                 4'((c < 6) ? c / 2 : 3), 4'((c < 6) ? (c + 1) / 2 : 3));

        // TDM isolation, P2 idle
        step("tdm1 rst", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
        for (int c = 0; c < 14; c++)
            step($sformatf("tdm1 c%0d", c), 1, 1, c < 12, 0, 0, 0,
                 (c < 4) || ((c >= 8) && (c < 12)), 0,
                 ((c >= 2) && (c <= 5)) || (c >= 10), 0,
                 (c != 0) && ((c <= 5) || (c >= 9)), 1,
                 4'((c <= 4) ? 0 : ((c <= 8) ? c - 4 : 4)), 4'd0);

        // TDM isolation, P2 toggling: identical grant_1 trace
        step("tdm2 rst", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
        tally = 0;
        for (int c = 0; c < 14; c++) begin
            g2 = (c < 12) && pat[c % 12] && (c >= 4) && (c <= 7);
            step($sformatf("tdm2 c%0d", c), 1, 1, c < 12, (c < 12) && pat[c % 12], 0, 0,
                 (c < 4) || ((c >= 8) && (c < 12)), g2,
                 ((c >= 2) && (c <= 5)) || (c >= 10), c == 8,
                 (c != 0) && (c != 6), 1,
                 4'((c <= 4) ? 0 : ((c <= 8) ? c - 4 : 4)), 4'(tally));
            if ((c < 12) && pat[c % 12] && !g2) tally++;
        end

        // Flush squash, same-cycle squash, reset discarding an in-flight tag
        step("fl rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
        step("fl t0",  1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 4'd0, 4'd0);
        step("fl t1",  1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 4'd0, 4'd0);
        step("fl t2",  1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 4'd0, 4'd0);
        step("fl t3",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0, 4'd0);
        step("fl t4",  1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'd0, 4'd0);
        step("fl t5",  1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 4'd1, 4'd0);
        step("fl t6",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0, 4'd0);
        step("fl t7",  1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 4'd0, 4'd0);
        step("fl t8",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd1, 4'd0);
        step("fl t9",  1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'd0, 4'd0);
        step("fl t10", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
        step("fl t11", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0, 4'd0);

        // RR to TDM switch mid-burst
        step("ms rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
        for (int c = 0; c < 12; c++)
            step($sformatf("ms c%0d", c), 1, c >= 2, c < 11, c < 11, 0, 0,
                 (c == 0) || ((c >= 2) && (c <= 6)), (c == 1) || ((c >= 7) && (c <= 10)),
                 (c == 2) || ((c >= 4) && (c <= 8)), (c == 3) || (c >= 9),
                 c >= 1, c == 11, 4'd5, 4'd6);

        // Stall counter saturation
        step("sat rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
        for (int c = 0; c < 21; c++)
            step($sformatf("sat c%0d", c), 1, 0, 0, c < 20, 0, c < 20,
                 0, 0, 0, 0, 0, 1, 4'd0, 4'((c > 15) ? 15 : c));

        @(negedge clk);
        for (int i = 0; (i < 10) && (sb.size() > 0); i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
